// File: rtl/spiflash_responder.sv
// SPI flash responder: oversamples csb/clk/io on the system clock and serves 0x03 reads from a byte-wide memory port.
// Define SPIFLASH_QUAD_EN to add the 0xEB quad I/O read (QADDR/MODE/DUMMY/QDATA).
module spiflash_responder #(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_csb,
  input  logic              spi_clk,
  input  logic [3:0]        spi_io_di,
  output logic [3:0]        spi_io_do,
  output logic [3:0]        spi_io_oe,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              underrun
);

`ifdef SPIFLASH_QUAD_EN
  typedef enum logic [3:0] {IDLE, CMD, ADDR, DATA, IGNORE, QADDR, MODE, DUMMY, QDATA} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif

  state_t state, state_nx;

  logic [SYNC_FF-1:0][5:0] sync_q;
  logic        csb_s, sclk_s, sclk_d;
  logic [3:0]  io_s;
  logic        rise, fall;
  logic [4:0]  cnt;
  logic [2:0]  ocnt;
  logic [22:0] sreg;
  logic [7:0]  cmd_byte;
  logic [23:0] addr_next;
  logic [7:0]  sh, pbuf, ld_byte;
  logic        pbuf_vld, drv, out_st, load_now;
  logic [3:0]  do_r;
  logic        unused_bits;

  // Element 0 is the newest sample; csb resets high so a reset looks like "deselected".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {SYNC_FF{6'b100000}};
      sclk_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_FF-2:0], {spi_csb, spi_clk, spi_io_di}};
      sclk_d <= sclk_s;
    end
  end

  assign csb_s  = sync_q[SYNC_FF-1][5];
  assign sclk_s = sync_q[SYNC_FF-1][4];
  assign io_s   = sync_q[SYNC_FF-1][3:0];
  assign rise   = ~csb_s & sclk_s & ~sclk_d;
  assign fall   = ~csb_s & ~sclk_s & sclk_d;

  assign cmd_byte  = {sreg[6:0], io_s[0]};
`ifdef SPIFLASH_QUAD_EN
  assign addr_next = (state == QADDR) ? {sreg[19:0], io_s} : {sreg[22:0], io_s[0]};
  assign out_st    = (state == DATA) || (state == QDATA);
`else
  assign addr_next = {sreg[22:0], io_s[0]};
  assign out_st    = (state == DATA);
`endif
  assign ld_byte     = pbuf_vld ? pbuf : 8'hFF;
  assign load_now    = fall && out_st && (ocnt == '0);
  assign unused_bits = ^{io_s, addr_next};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (csb_s) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = CMD;
        CMD: if (rise && cnt == 5'd7) begin
          if (cmd_byte == 8'h03)      state_nx = ADDR;
`ifdef SPIFLASH_QUAD_EN
          else if (cmd_byte == 8'hEB) state_nx = QADDR;
`endif
          else                        state_nx = IGNORE;
        end
        ADDR:  if (rise && cnt == 5'd23) state_nx = DATA;
`ifdef SPIFLASH_QUAD_EN
        QADDR: if (rise && cnt == 5'd5)  state_nx = MODE;
        MODE:  if (rise && cnt == 5'd1)  state_nx = DUMMY;
        DUMMY: if (rise && cnt == 5'd3)  state_nx = QDATA;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    spi_io_oe = '0;
    if (drv && state == DATA) spi_io_oe = 4'b0010;
`ifdef SPIFLASH_QUAD_EN
    if (drv && state == QDATA) spi_io_oe = 4'b1111;
`endif
  end

  assign spi_io_do = do_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      ocnt      <= '0;
      sreg      <= '0;
      sh        <= '0;
      pbuf      <= '0;
      pbuf_vld  <= 1'b0;
      drv       <= 1'b0;
      do_r      <= '0;
      mem_addr  <= '0;
      mem_valid <= 1'b0;
      underrun  <= 1'b0;
    end else if (csb_s) begin
      // Deselect wins over any same-cycle spi_clk edge and drops the outstanding request.
      cnt       <= '0;
      ocnt      <= '0;
      pbuf_vld  <= 1'b0;
      drv       <= 1'b0;
      do_r      <= '0;
      mem_valid <= 1'b0;
    end else begin
      if (state == IDLE) underrun <= 1'b0;

      if (state_nx != state) cnt <= '0;
      else if (rise)         cnt <= cnt + 5'd1;

      if (rise && (state == CMD || state == ADDR)) sreg <= {sreg[21:0], io_s[0]};
`ifdef SPIFLASH_QUAD_EN
      if (rise && state == QADDR) sreg <= {sreg[18:0], io_s};
`endif

      if (mem_valid && mem_ready) begin
        pbuf      <= mem_rdata;
        pbuf_vld  <= 1'b1;
        mem_valid <= 1'b0;
      end

`ifdef SPIFLASH_QUAD_EN
      if (rise && ((state == ADDR && cnt == 5'd23) || (state == QADDR && cnt == 5'd5))) begin
`else
      if (rise && state == ADDR && cnt == 5'd23) begin
`endif
        mem_addr  <= addr_next[ADDR_W-1:0];
        mem_valid <= 1'b1;
        pbuf_vld  <= 1'b0;
      end

      if (fall && state == DATA) begin
        drv  <= 1'b1;
        ocnt <= ocnt + 3'd1;
        if (ocnt == '0) begin
          do_r <= {2'b00, ld_byte[7], 1'b0};
          sh   <= {ld_byte[6:0], 1'b0};
        end else begin
          do_r <= {2'b00, sh[7], 1'b0};
          sh   <= {sh[6:0], 1'b0};
        end
      end
`ifdef SPIFLASH_QUAD_EN
      if (fall && state == QDATA) begin
        drv  <= 1'b1;
        ocnt <= (ocnt == '0) ? 3'd1 : 3'd0;
        if (ocnt == '0) begin
          do_r <= ld_byte[7:4];
          sh   <= {ld_byte[3:0], 4'h0};
        end else begin
          do_r <= sh[7:4];
          sh   <= {sh[3:0], 4'h0};
        end
      end
`endif

      // On underrun the request stays outstanding at the same address; its data serves the next byte.
      if (load_now) begin
        if (pbuf_vld) begin
          pbuf_vld  <= 1'b0;
          mem_addr  <= mem_addr + ADDR_W'(1);
          mem_valid <= 1'b1;
        end else begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule
